// File: rtl/nonce_sched_pkg.sv
// nonce_sched_pkg: shared widths and state encoding for the nonce scheduler.
package nonce_sched_pkg;
    localparam int WORD_W = 32;
    localparam int WORD_N = 16;
    localparam int WARR_S = WORD_W * WORD_N;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/nonce_sched_if.sv
// nonce_sched_if: job, hit and issue signals of the nonce scheduler.
// Optional hash_count exists only when NONCE_SCHED_HASHCNT_EN is defined.
interface nonce_sched_if;
    import nonce_sched_pkg::*;
    logic              job_valid;
    logic              job_ready;
    logic [WARR_S-1:0] job_block;
    logic [31:0]       job_nonce_start;
    logic [31:0]       job_nonce_end;
    logic              abort;
    logic              hit_valid;
    logic [31:0]       hit_nonce;
    logic [WARR_S-1:0] W;
    logic              en;
    logic              busy;
    logic              done;
    logic              found;
    logic [31:0]       found_nonce;
`ifdef NONCE_SCHED_HASHCNT_EN
    logic [63:0]       hash_count;
`endif
    modport master (
        output job_valid, job_block, job_nonce_start, job_nonce_end, abort, hit_valid, hit_nonce,
`ifdef NONCE_SCHED_HASHCNT_EN
        input  hash_count,
`endif
        input  job_ready, W, en, busy, done, found, found_nonce
    );
    modport slave (
        input  job_valid, job_block, job_nonce_start, job_nonce_end, abort, hit_valid, hit_nonce,
`ifdef NONCE_SCHED_HASHCNT_EN
        output hash_count,
`endif
        output job_ready, W, en, busy, done, found, found_nonce
    );
endinterface

// File: rtl/nonce_sched.sv
// nonce_sched: issues one nonce-spliced block per cycle for a job, drains the pipe, reports the first hit.
// Define NONCE_SCHED_HASHCNT_EN to add a 64-bit hash_count of issued blocks.
module nonce_sched
    import nonce_sched_pkg::*;
#(
    parameter int PIPE_DEPTH = 64,
    parameter int NONCE_WORD = 3
) (
    input logic          clk,
    input logic          reset,
    nonce_sched_if.slave bus
);
    localparam int CW = $clog2(PIPE_DEPTH + 1);

    state_t            state_q, state_d;
    logic [31:0]       nonce_q, nonce_d, end_q, end_d, found_nonce_q, found_nonce_d;
    logic [WARR_S-1:0] block_q, block_d, w;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              found_q, found_d, accept, active, capture;
`ifdef NONCE_SCHED_HASHCNT_EN
    logic [63:0]       hash_q, hash_d;
`endif

    assign accept  = state_q == S_IDLE && bus.job_valid;
    assign active  = state_q == S_RUN || state_q == S_DRAIN;
    // abort beats a simultaneous hit, and only the first hit of a job sticks
    assign capture = active && bus.hit_valid && !bus.abort && !found_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            nonce_q       <= '0;
            end_q         <= '0;
            block_q       <= '0;
            cnt_q         <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
`ifdef NONCE_SCHED_HASHCNT_EN
            hash_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            end_q         <= end_d;
            block_q       <= block_d;
            cnt_q         <= cnt_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
`ifdef NONCE_SCHED_HASHCNT_EN
            hash_q        <= hash_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = bus.job_valid ? S_RUN : S_IDLE;
            S_RUN:   state_d = bus.abort ? S_IDLE : (nonce_q == end_q || bus.hit_valid) ? S_DRAIN : S_RUN;
            S_DRAIN: state_d = bus.abort ? S_IDLE : cnt_q == '0 ? S_DONE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // cnt is reloaded every RUN cycle so it holds PIPE_DEPTH on DRAIN entry
    always_comb begin
        nonce_d       = accept ? bus.job_nonce_start : state_q == S_RUN ? nonce_q + 32'd1 : nonce_q;
        end_d         = accept ? bus.job_nonce_end : end_q;
        block_d       = accept ? bus.job_block : block_q;
        cnt_d         = state_q == S_RUN ? CW'(PIPE_DEPTH) : state_q == S_DRAIN && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
        found_d       = accept ? 1'b0 : capture ? 1'b1 : found_q;
        found_nonce_d = accept ? 32'd0 : capture ? bus.hit_nonce : found_nonce_q;
`ifdef NONCE_SCHED_HASHCNT_EN
        hash_d        = hash_q + 64'(state_q == S_RUN);
`endif
    end

    for (genvar i = 0; i < WORD_N; i++) begin : g_w
        assign w[WARR_S-1-WORD_W*i -: WORD_W] = i == NONCE_WORD ? nonce_q : block_q[WARR_S-1-WORD_W*i -: WORD_W];
    end

    assign bus.job_ready   = state_q == S_IDLE;
    assign bus.busy        = state_q != S_IDLE;
    assign bus.en          = state_q == S_RUN;
    assign bus.done        = state_q == S_DONE;
    assign bus.found       = found_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.W           = w;
`ifdef NONCE_SCHED_HASHCNT_EN
    assign bus.hash_count  = hash_q;
`endif
endmodule

// File: tb/tb_nonce_sched.sv
// tb_nonce_sched: randomized and directed jobs checked cycle by cycle against an arithmetic model of issue/drain/done timing.
module tb_nonce_sched;
    localparam int PD = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_hash = '0;
    logic last_found = 1'b0;
    logic [31:0] last_fn = '0;

    nonce_sched_if bus();

    nonce_sched #(.PIPE_DEPTH(PD), .NONCE_WORD(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hc1/hc2: relative cycles of the first/second hit (0 = none); ab_c: abort cycle (0 = none)
    task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int hc1, input int hc2,
                           input int ab_c, input logic [31:0] hn, input logic [511:0] blk);
        int n, n_iss, last;
        bit cap, live, exp_en, exp_done, exp_ready;
        logic [511:0] exp_w;
        n     = int'(e - s) + 1;
        n_iss = (hc1 >= 1 && hc1 <= n) ? hc1 : n;
        cap   = hc1 >= 1 && hc1 <= n_iss + 1 + PD && (ab_c == 0 || hc1 < ab_c);
        last  = ab_c != 0 ? ab_c + 3 : n_iss + 3 + PD;
        chk("ready_before_job", bus.job_ready, 1'b1);
        bus.job_block = blk;
        bus.job_nonce_start = s;
        bus.job_nonce_end = e;
        bus.job_valid = 1'b1;
        for (int c = 1; c <= last; c++) begin
            step();
            bus.job_valid = 1'b0;
            bus.hit_valid = c == hc1 || c == hc2;
            bus.hit_nonce = c == hc1 ? hn : hn + 32'd1;
            bus.abort = c == ab_c;
            live      = ab_c == 0 || c <= ab_c;
            exp_en    = live && c <= n_iss;
            exp_done  = ab_c == 0 && c == n_iss + 2 + PD;
            exp_ready = (ab_c != 0 && c > ab_c) || c >= n_iss + 3 + PD;
            chk($sformatf("en c%0d", c), bus.en, exp_en);
            chk($sformatf("done c%0d", c), bus.done, exp_done);
            chk($sformatf("ready c%0d", c), bus.job_ready, exp_ready);
            chk($sformatf("busy c%0d", c), bus.busy, !exp_ready);
            if (c == 1) chk("found_cleared", bus.found, 1'b0);
            if (exp_en) begin
                exp_w = blk;
                exp_w[511-32*3 -: 32] = s + 32'(c - 1);
                chk($sformatf("W c%0d", c), bus.W, exp_w);
            end
            if (exp_done || (ab_c != 0 && c == ab_c + 1)) begin
                chk("found", bus.found, cap);
                chk("found_nonce", bus.found_nonce, cap ? hn : 32'd0);
            end
        end
        bus.hit_valid = 1'b0;
        bus.abort = 1'b0;
        exp_hash += 64'(ab_c != 0 && ab_c < n_iss ? ab_c : n_iss);
`ifdef NONCE_SCHED_HASHCNT_EN
        chk("hash_count", bus.hash_count, exp_hash);
`endif
        last_found = cap;
        last_fn = cap ? hn : 32'd0;
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        bus.job_valid = 1'b0;
        bus.job_block = '0;
        bus.job_nonce_start = '0;
        bus.job_nonce_end = '0;
        bus.abort = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_nonce = '0;
        repeat (3) step();
        chk("rst_en", bus.en, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_found", bus.found, 1'b0);
        chk("rst_found_nonce", bus.found_nonce, 32'd0);
        chk("rst_W", bus.W, 512'd0);
        chk("rst_ready", bus.job_ready, 1'b1);
        reset = 1'b1;
        step();
        run_job(32'h10, 32'h13, 0, 0, 0, 32'h0, rnd_blk());
        run_job(32'hFFFF_FFFE, 32'h1, 0, 0, 0, 32'h0, rnd_blk());
        run_job(32'h200, 32'h20F, 3, 5, 0, 32'hABCD, rnd_blk());
        // hit and abort while idle must be ignored
        bus.hit_valid = 1'b1;
        bus.abort = 1'b1;
        bus.hit_nonce = 32'h5555;
        step();
        bus.hit_valid = 1'b0;
        bus.abort = 1'b0;
        chk("idle_hit_found", bus.found, last_found);
        chk("idle_hit_nonce", bus.found_nonce, last_fn);
        chk("idle_abort_ready", bus.job_ready, 1'b1);
        run_job(32'h300, 32'h30A, 0, 0, 0, 32'h0, rnd_blk());
        run_job(32'h400, 32'h40F, 4, 0, 4, 32'h77, rnd_blk());
        run_job(32'h7, 32'h7, 0, 0, 0, 32'h0, rnd_blk());
        for (int k = 0; k < 4; k++) begin
            automatic logic [31:0] s = $urandom;
            automatic int len = int'($urandom_range(1, 6));
            run_job(s, s + 32'(len - 1), int'($urandom_range(0, len + 2)), 0, 0, $urandom, rnd_blk());
        end
        // async reset in the middle of DRAIN with a captured hit
        bus.job_block = rnd_blk();
        bus.job_nonce_start = 32'h100;
        bus.job_nonce_end = 32'h104;
        bus.job_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.job_valid = 1'b0;
            bus.hit_valid = c == 2;
            bus.hit_nonce = 32'hBEEF;
        end
        bus.hit_valid = 1'b0;
        chk("pre_rst_found", bus.found, 1'b1);
        chk("pre_rst_busy", bus.busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_en", bus.en, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_found", bus.found, 1'b0);
        chk("arst_found_nonce", bus.found_nonce, 32'd0);
        chk("arst_W", bus.W, 512'd0);
        chk("arst_ready", bus.job_ready, 1'b1);
        exp_hash = '0;
        step();
        reset = 1'b1;
        step();
        run_job(32'h50, 32'h54, 0, 0, 0, 32'h0, rnd_blk());
        run_job(32'h60, 32'h62, 0, 0, 0, 32'h0, rnd_blk());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
